// File: rtl/rotary_dev_pkg.sv
// Shared definitions for the rotary encoder decoder: status bit map,
// write-control bits, Gray-code states and the clockwise successor helper.
package rotary_dev_pkg;

  localparam int CNT_LSB   = 0;
  localparam int CNT_MSB   = 15;
  localparam int DIR_BIT   = 16;
  localparam int STEP_BIT  = 17;
  localparam int ERR_BIT   = 18;
  localparam int BTN_BIT   = 19;
  localparam int PRESS_BIT = 20;

  localparam int WR_LOAD = 31;
  localparam int WR_CLR  = 30;

  typedef enum logic [1:0] {
    GRAY_00 = 2'b00,
    GRAY_01 = 2'b01,
    GRAY_11 = 2'b11,
    GRAY_10 = 2'b10
  } gray_e;

  // Clockwise order is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic gray_e cwNext(gray_e g);
    case (g)
      GRAY_00: return GRAY_01;
      GRAY_01: return GRAY_11;
      GRAY_11: return GRAY_10;
      default: return GRAY_00;
    endcase
  endfunction

endpackage

// File: rtl/rotary_dev_if.sv
// CPU-side bus of the rotary decoder: write strobe, write data, status read.
interface rotary_dev_if;
  logic        we8;
  logic [31:0] d;
  logic [31:0] q;

  modport master (output we8, output d, input q);
  modport slave  (input we8, input d, output q);
endinterface

// File: rtl/rot_debounce.sv
// One encoder pin: two-flop synchroniser followed by a stability filter.
// The filtered level follows the synced pin only after it has disagreed
// for DEBOUNCE_CYCLES consecutive clocks; any agreeing sample restarts.
module rot_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd5000
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic level_o
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic [15:0] cnt_q, cnt_d;

  // Count consecutive disagreeing samples and accept the new level on the last one.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= DEBOUNCE_CYCLES - 16'd1) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Synchroniser and filter registers, cleared by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/rotary_dev.sv
// Memory-mapped quadrature rotary encoder: debounced A/B/button, Gray decode,
// substep accumulator, wrapping signed count, sticky flags and CPU write port.
module rotary_dev
  import rotary_dev_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES  = 16'd5000,
  parameter int          STEPS_PER_DETENT = 4
) (
  input  logic          clk,
  input  logic          reset,
  rotary_dev_if.slave   bus,
  input  logic          rot_a,
  input  logic          rot_b,
  input  logic          rot_center
);

  localparam logic signed [3:0] ACC_TOP = 4'(STEPS_PER_DETENT);

  logic aFilt, bFilt, btnFilt;

  rot_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebA (
    .clk(clk), .reset(reset), .pin_i(rot_a), .level_o(aFilt));
  rot_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebB (
    .clk(clk), .reset(reset), .pin_i(rot_b), .level_o(bFilt));
  rot_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebC (
    .clk(clk), .reset(reset), .pin_i(rot_center), .level_o(btnFilt));

  gray_e              gray_q, gray_d, curAb;
  logic               primed_q, primed_d;
  logic signed [3:0]  acc_q, acc_d, subStep, accSum;
  logic [15:0]        count_q, count_d;
  logic               dir_q, dir_d;
  logic               stepFlag_q, stepFlag_d;
  logic               errFlag_q, errFlag_d;
  logic               pressFlag_q, pressFlag_d;
  logic               btnLast_q;
  logic               errEvt, wrLoad, wrClr;
  logic               unusedBits;

  assign unusedBits = ^bus.d[29:16];
  assign wrLoad     = bus.we8 & bus.d[WR_LOAD];
  assign wrClr      = bus.we8 & bus.d[WR_CLR];

  // Decode the Gray transition, advance the accumulator and apply CPU writes.
  always_comb begin
    gray_d      = gray_q;
    primed_d    = 1'b1;
    acc_d       = acc_q;
    count_d     = count_q;
    dir_d       = dir_q;
    stepFlag_d  = stepFlag_q;
    errFlag_d   = errFlag_q;
    pressFlag_d = pressFlag_q;
    subStep     = 4'sd0;
    errEvt      = 1'b0;
    curAb       = gray_e'({aFilt, bFilt});

    if (primed_q && (curAb != gray_q)) begin
      if (curAb == cwNext(gray_q)) begin
        subStep = 4'sd1;
      end else if (gray_q == cwNext(curAb)) begin
        subStep = -4'sd1;
      end else begin
        errEvt = 1'b1;
      end
    end
    gray_d = curAb;
    accSum = acc_q + subStep;

    if (wrClr) begin
      stepFlag_d  = 1'b0;
      errFlag_d   = 1'b0;
      pressFlag_d = 1'b0;
    end

    if (wrLoad) begin
      count_d = bus.d[CNT_MSB:CNT_LSB];
      acc_d   = 4'sd0;
    end else if (accSum == ACC_TOP) begin
      count_d    = count_q + 16'd1;
      dir_d      = 1'b1;
      stepFlag_d = 1'b1;
      acc_d      = 4'sd0;
    end else if (accSum == -ACC_TOP) begin
      count_d    = count_q - 16'd1;
      dir_d      = 1'b0;
      stepFlag_d = 1'b1;
      acc_d      = 4'sd0;
    end else begin
      acc_d = accSum;
    end

    if (errEvt) errFlag_d = 1'b1;
    if (btnFilt && !btnLast_q) pressFlag_d = 1'b1;
  end

  // Decoder state; the first clock after reset only adopts the filtered pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gray_q      <= GRAY_00;
      primed_q    <= 1'b0;
      acc_q       <= 4'sd0;
      count_q     <= '0;
      dir_q       <= 1'b0;
      stepFlag_q  <= 1'b0;
      errFlag_q   <= 1'b0;
      pressFlag_q <= 1'b0;
      btnLast_q   <= 1'b0;
    end else begin
      gray_q      <= gray_d;
      primed_q    <= primed_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      dir_q       <= dir_d;
      stepFlag_q  <= stepFlag_d;
      errFlag_q   <= errFlag_d;
      pressFlag_q <= pressFlag_d;
      btnLast_q   <= btnFilt;
    end
  end

  // Status word assembled from the flops.
  always_comb begin
    bus.q                   = '0;
    bus.q[CNT_MSB:CNT_LSB]  = count_q;
    bus.q[DIR_BIT]          = dir_q;
    bus.q[STEP_BIT]         = stepFlag_q;
    bus.q[ERR_BIT]          = errFlag_q;
    bus.q[BTN_BIT]          = btnFilt;
    bus.q[PRESS_BIT]        = pressFlag_q;
  end

endmodule
